// File: rtl/tb_ethernet_reply_tx_arbiter.sv
// Round-robin transmit arbiter for the ARP/ICMP/UDP reply builders.
// Each source has a one-entry frame buffer; the granted frame is streamed as 64-bit beats.
module tb_ethernet_reply_tx_arbiter #(
  parameter int IFG_CYCLES  = 1,
  parameter int MAX_PAYLOAD = 63
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [431:0] i_arp_reply,
  input  logic         i_arp_reply_ready,
  input  logic [399:0] i_icmp_reply_head,
  input  logic [503:0] i_icmp_reply_payload,
  input  logic [5:0]   i_icmp_reply_payload_size,
  input  logic         i_icmp_reply_ready,
  input  logic [399:0] i_udp_reply_head,
  input  logic [503:0] i_udp_reply_payload,
  input  logic [15:0]  i_udp_reply_payload_size,
  input  logic         i_udp_reply_ready,
  output logic [63:0]  o_tx_data,
  output logic [7:0]   o_tx_keep,
  output logic         o_tx_valid,
  output logic         o_tx_last,
  input  logic         i_tx_ready,
  output logic [1:0]   o_tx_src,
  output logic         o_busy,
  output logic [2:0]   o_drop,
  output logic         o_size_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ARP  = 2'd1;
  localparam logic [1:0] SRC_ICMP = 2'd2;
  localparam logic [1:0] SRC_UDP  = 2'd3;

  localparam int              GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [6:0]      MAX_P    = 7'(MAX_PAYLOAD);

  state_t         state;
  state_t         next_state;
  logic [2:0]     pending;
  logic [1:0]     grant;
  logic [1:0]     pick;
  logic [1:0]     cand;
  logic [3:0]     beat_cnt;
  logic [GW-1:0]  gap_cnt;

  logic [431:0]   arp_buf;
  logic [399:0]   icmp_head;
  logic [399:0]   udp_head;
  logic [503:0]   icmp_pay;
  logic [503:0]   udp_pay;
  logic [6:0]     icmp_len;
  logic [6:0]     udp_len;

  logic [2:0]     req;
  logic [2:0]     accept;
  logic [2:0]     reject;
  logic [2:0]     clear_mask;
  logic [6:0]     icmp_pl;
  logic [6:0]     udp_pl;
  logic           udp_over;

  logic [959:0]   sel_frame;
  logic [6:0]     sel_len;
  logic [3:0]     last_beat;
  logic [7:0]     last_keep;
  logic [7:0]     cur_keep;
  logic [63:0]    beat_word;
  logic [63:0]    beat_data;
  logic           is_last;
  logic           hs;
  logic           done;

  // A pulse is only taken when the source's flag was clear at that edge; the
  // clear from a last-beat handshake never frees the slot for the same cycle.
  always_comb begin
    req      = {i_udp_reply_ready, i_icmp_reply_ready, i_arp_reply_ready};
    accept   = req & ~pending;
    reject   = req & pending;
    icmp_pl  = ({1'b0, i_icmp_reply_payload_size} > MAX_P) ? MAX_P
                                                            : {1'b0, i_icmp_reply_payload_size};
    udp_over = i_udp_reply_payload_size > 16'(MAX_PAYLOAD);
    udp_pl   = udp_over ? MAX_P : i_udp_reply_payload_size[6:0];
  end

  // Round-robin: the first pending source after the last grant wins.
  always_comb begin
    pick = SRC_NONE;
    cand = SRC_NONE;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'(((int'(grant) + k - 1) % 3) + 1);
      if (pending[cand - 2'd1]) pick = cand;
    end
  end

  // Frames are left-aligned in a 120-byte window so every beat is a fixed-size slice.
  always_comb begin
    sel_frame = '0;
    sel_len   = '0;
    case (grant)
      SRC_ARP: begin
        sel_frame = {arp_buf, 528'd0};
        sel_len   = 7'd54;
      end
      SRC_ICMP: begin
        sel_frame = {icmp_head, icmp_pay, 56'd0};
        sel_len   = icmp_len;
      end
      SRC_UDP: begin
        sel_frame = {udp_head, udp_pay, 56'd0};
        sel_len   = udp_len;
      end
      default: begin
        sel_frame = '0;
        sel_len   = '0;
      end
    endcase
    last_beat = 4'((sel_len - 7'd1) >> 3);
    last_keep = (sel_len[2:0] == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, sel_len[2:0]}));
    is_last   = (beat_cnt == last_beat);
    cur_keep  = is_last ? last_keep : 8'hFF;
    beat_word = sel_frame[959 - 64 * int'(beat_cnt) -: 64];
    beat_data = '0;
    for (int j = 0; j < 8; j++) begin
      beat_data[8*j +: 8] = beat_word[63 - 8*j -: 8] & {8{cur_keep[j]}};
    end
  end

  // Handshake: a beat transfers on a rising edge with o_tx_valid & i_tx_ready;
  // once valid rises it stays high with data/keep/last frozen until that transfer.
  always_comb begin
    hs         = (state == S_SEND) && i_tx_ready;
    done       = hs && is_last;
    clear_mask = {done && (grant == SRC_UDP), done && (grant == SRC_ICMP),
                  done && (grant == SRC_ARP)};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (pick != SRC_NONE) next_state = S_SEND;
      S_SEND: if (done) next_state = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (gap_cnt == GAP_LAST) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    o_tx_keep  = '0;
    o_tx_last  = 1'b0;
    o_tx_src   = SRC_NONE;
    o_busy     = (state != S_IDLE);
    if (state == S_SEND) begin
      o_tx_valid = 1'b1;
      o_tx_data  = beat_data;
      o_tx_keep  = cur_keep;
      o_tx_last  = is_last;
      o_tx_src   = grant;
    end
  end

  // grant resets to UDP so the first search starts at ARP.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pending    <= '0;
      grant      <= SRC_UDP;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      o_drop     <= '0;
      o_size_err <= 1'b0;
    end else begin
      pending    <= (pending & ~clear_mask) | accept;
      o_drop     <= reject;
      o_size_err <= accept[2] && udp_over;
      if (state == S_IDLE && pick != SRC_NONE) begin
        grant    <= pick;
        beat_cnt <= '0;
      end else if (hs && !is_last) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      arp_buf   <= '0;
      icmp_head <= '0;
      icmp_pay  <= '0;
      icmp_len  <= '0;
      udp_head  <= '0;
      udp_pay   <= '0;
      udp_len   <= '0;
    end else begin
      if (accept[0]) arp_buf <= i_arp_reply;
      if (accept[1]) begin
        icmp_head <= i_icmp_reply_head;
        icmp_pay  <= i_icmp_reply_payload;
        icmp_len  <= 7'd50 + icmp_pl;
      end
      if (accept[2]) begin
        udp_head <= i_udp_reply_head;
        udp_pay  <= i_udp_reply_payload;
        udp_len  <= 7'd50 + udp_pl;
      end
    end
  end

endmodule

// File: tb/tb_tb_ethernet_reply_tx_arbiter.sv
// Directed bench for the reply TX arbiter: latency, framing, keep, round-robin,
// inter-frame gap, backpressure, drops, size clamp and mid-frame reset.
module tb_tb_ethernet_reply_tx_arbiter;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic [431:0] i_arp_reply;
  logic         i_arp_reply_ready;
  logic [399:0] i_icmp_reply_head;
  logic [503:0] i_icmp_reply_payload;
  logic [5:0]   i_icmp_reply_payload_size;
  logic         i_icmp_reply_ready;
  logic [399:0] i_udp_reply_head;
  logic [503:0] i_udp_reply_payload;
  logic [15:0]  i_udp_reply_payload_size;
  logic         i_udp_reply_ready;
  logic [63:0]  o_tx_data;
  logic [7:0]   o_tx_keep;
  logic         o_tx_valid;
  logic         o_tx_last;
  logic         i_tx_ready;
  logic [1:0]   o_tx_src;
  logic         o_busy;
  logic [2:0]   o_drop;
  logic         o_size_err;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  tb_ethernet_reply_tx_arbiter #(.IFG_CYCLES(1), .MAX_PAYLOAD(63)) dut (
    .i_clk                     (i_clk),
    .i_reset                   (i_reset),
    .i_arp_reply               (i_arp_reply),
    .i_arp_reply_ready         (i_arp_reply_ready),
    .i_icmp_reply_head         (i_icmp_reply_head),
    .i_icmp_reply_payload      (i_icmp_reply_payload),
    .i_icmp_reply_payload_size (i_icmp_reply_payload_size),
    .i_icmp_reply_ready        (i_icmp_reply_ready),
    .i_udp_reply_head          (i_udp_reply_head),
    .i_udp_reply_payload       (i_udp_reply_payload),
    .i_udp_reply_payload_size  (i_udp_reply_payload_size),
    .i_udp_reply_ready         (i_udp_reply_ready),
    .o_tx_data                 (o_tx_data),
    .o_tx_keep                 (o_tx_keep),
    .o_tx_valid                (o_tx_valid),
    .o_tx_last                 (o_tx_last),
    .i_tx_ready                (i_tx_ready),
    .o_tx_src                  (o_tx_src),
    .o_busy                    (o_busy),
    .o_drop                    (o_drop),
    .o_size_err                (o_size_err)
  );

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Frame byte idx of source src (1 ARP, 2 ICMP, 3 UDP) carries this value.
  function automatic logic [7:0] fbyte(input int src, input int idx);
    return 8'((idx * 5) + (src * 40) + 1);
  endfunction

  function automatic logic [63:0] exp_data(input int src, input int len, input int k);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < len) d[8*j +: 8] = fbyte(src, 8*k + j);
    return d;
  endfunction

  function automatic logic [7:0] exp_keep(input int len, input int k);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < len) m[j] = 1'b1;
    return m;
  endfunction

  task automatic fill_frames();
    for (int i = 0; i < 54; i++) i_arp_reply[431 - 8*i -: 8] = fbyte(1, i);
    for (int i = 0; i < 50; i++) begin
      i_icmp_reply_head[399 - 8*i -: 8] = fbyte(2, i);
      i_udp_reply_head[399 - 8*i -: 8]  = fbyte(3, i);
    end
    for (int p = 0; p < 63; p++) begin
      i_icmp_reply_payload[503 - 8*p -: 8] = fbyte(2, 50 + p);
      i_udp_reply_payload[503 - 8*p -: 8]  = fbyte(3, 50 + p);
    end
  endtask

  // Consume a frame from beat first_beat on; optionally stall at stall_beat.
  task automatic rx_frame(input int src, input int len, input int first_beat,
                          input int stall_beat, input int stall_cyc);
    int nb;
    int waited;
    nb = (len + 7) / 8;
    waited = 0;
    while (!o_tx_valid && waited < 40) begin
      step();
      waited++;
    end
    chk($sformatf("s%0d_valid_wait", src), 64'(o_tx_valid), 64'd1);
    for (int k = first_beat; k < nb; k++) begin
      if (k == stall_beat) begin
        i_tx_ready = 1'b0;
        for (int c = 0; c < stall_cyc; c++) begin
          chk($sformatf("s%0d_stall%0d_valid", src, c), 64'(o_tx_valid), 64'd1);
          chk($sformatf("s%0d_stall%0d_data", src, c), o_tx_data, exp_data(src, len, k));
          chk($sformatf("s%0d_stall%0d_keep", src, c), 64'(o_tx_keep), 64'(exp_keep(len, k)));
          chk($sformatf("s%0d_stall%0d_last", src, c), 64'(o_tx_last), 64'(k == nb - 1));
          step();
        end
        i_tx_ready = 1'b1;
      end
      chk($sformatf("s%0d_b%0d_valid", src, k), 64'(o_tx_valid), 64'd1);
      chk($sformatf("s%0d_b%0d_data", src, k), o_tx_data, exp_data(src, len, k));
      chk($sformatf("s%0d_b%0d_keep", src, k), 64'(o_tx_keep), 64'(exp_keep(len, k)));
      chk($sformatf("s%0d_b%0d_last", src, k), 64'(o_tx_last), 64'(k == nb - 1));
      chk($sformatf("s%0d_b%0d_src", src, k), 64'(o_tx_src), 64'(src));
      step();
    end
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (o_tx_valid) seen++;
      step();
    end
  endtask

  int extra;

  initial begin
    i_arp_reply = '0; i_icmp_reply_head = '0; i_icmp_reply_payload = '0;
    i_udp_reply_head = '0; i_udp_reply_payload = '0;
    i_arp_reply_ready = 1'b0; i_icmp_reply_ready = 1'b0; i_udp_reply_ready = 1'b0;
    i_icmp_reply_payload_size = '0; i_udp_reply_payload_size = '0;
    i_tx_ready = 1'b1;
    fill_frames();
    i_reset = 1'b1;
    step();
    step();

    chk("rst_data", o_tx_data, 64'd0);
    chk("rst_keep", 64'(o_tx_keep), 64'd0);
    chk("rst_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_last", 64'(o_tx_last), 64'd0);
    chk("rst_src", 64'(o_tx_src), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_drop", 64'(o_drop), 64'd0);
    chk("rst_size_err", 64'(o_size_err), 64'd0);
    i_reset = 1'b0;
    step();

    // Single ARP: 54 bytes, 7 beats, last keep 3F, valid two cycles after the pulse.
    i_arp_reply_ready = 1'b1;
    step();
    i_arp_reply_ready = 1'b0;
    chk("arp_lat1_valid", 64'(o_tx_valid), 64'd0);
    step();
    chk("arp_lat2_valid", 64'(o_tx_valid), 64'd1);
    chk("arp_busy", 64'(o_busy), 64'd1);
    chk("arp_b6_keep_const", 64'(exp_keep(54, 6)), 64'h3F);
    rx_frame(1, 54, 0, -1, 0);
    chk("arp_gap_valid", 64'(o_tx_valid), 64'd0);
    chk("arp_gap_busy", 64'(o_busy), 64'd1);
    step();
    chk("arp_idle_busy", 64'(o_busy), 64'd0);
    chk("arp_idle_src", 64'(o_tx_src), 64'd0);

    // ICMP size 0 (50 bytes, keep 03) then size 14 (64 bytes, keep FF).
    i_icmp_reply_payload_size = 6'd0;
    i_icmp_reply_ready = 1'b1;
    step();
    i_icmp_reply_ready = 1'b0;
    rx_frame(2, 50, 0, -1, 0);
    step(); step();
    i_icmp_reply_payload_size = 6'd14;
    i_icmp_reply_ready = 1'b1;
    step();
    i_icmp_reply_ready = 1'b0;
    rx_frame(2, 64, 0, -1, 0);
    step(); step();

    // UDP size 100: clamped to 63, 113 bytes, 15 beats, last keep 01.
    i_udp_reply_payload_size = 16'd100;
    i_udp_reply_ready = 1'b1;
    step();
    i_udp_reply_ready = 1'b0;
    chk("udp_size_err_pulse", 64'(o_size_err), 64'd1);
    chk("udp_no_drop", 64'(o_drop), 64'd0);
    step();
    chk("udp_size_err_clear", 64'(o_size_err), 64'd0);
    rx_frame(3, 113, 0, -1, 0);
    step(); step();

    // Simultaneous pulses: ARP, ICMP, UDP in order with two idle cycles between.
    i_icmp_reply_payload_size = 6'd14;
    i_udp_reply_payload_size  = 16'd10;
    i_arp_reply_ready = 1'b1; i_icmp_reply_ready = 1'b1; i_udp_reply_ready = 1'b1;
    step();
    i_arp_reply_ready = 1'b0; i_icmp_reply_ready = 1'b0; i_udp_reply_ready = 1'b0;
    chk("tri_no_drop", 64'(o_drop), 64'd0);
    chk("tri_no_size_err", 64'(o_size_err), 64'd0);
    step();
    rx_frame(1, 54, 0, -1, 0);
    chk("tri_gap1a", 64'(o_tx_valid), 64'd0);
    step();
    chk("tri_gap1b", 64'(o_tx_valid), 64'd0);
    step();
    chk("tri_icmp_start", 64'(o_tx_valid), 64'd1);
    rx_frame(2, 64, 0, -1, 0);
    chk("tri_gap2a", 64'(o_tx_valid), 64'd0);
    step();
    chk("tri_gap2b", 64'(o_tx_valid), 64'd0);
    step();
    chk("tri_udp_start", 64'(o_tx_valid), 64'd1);
    rx_frame(3, 60, 0, -1, 0);
    chk("tri_end_drop", 64'(o_drop), 64'd0);
    step(); step();

    // Backpressure: ready low for 5 cycles at beat 3.
    i_arp_reply_ready = 1'b1;
    step();
    i_arp_reply_ready = 1'b0;
    rx_frame(1, 54, 0, 3, 5);
    step(); step();

    // Second ARP pulse while ARP is transmitting is dropped.
    i_arp_reply_ready = 1'b1;
    step();
    i_arp_reply_ready = 1'b0;
    step();
    chk("drop_b0_valid", 64'(o_tx_valid), 64'd1);
    i_arp_reply_ready = 1'b1;
    step();
    i_arp_reply_ready = 1'b0;
    chk("drop_pulse", 64'(o_drop), 64'd1);
    step();
    chk("drop_clear", 64'(o_drop), 64'd0);
    rx_frame(1, 54, 2, -1, 0);
    count_valid(12, extra);
    chk("drop_single_frame", 64'(extra), 64'd0);

    // Reset at beat 2: outputs return to zero and the frame never resumes.
    i_arp_reply_ready = 1'b1;
    step();
    i_arp_reply_ready = 1'b0;
    step();
    step();
    step();
    chk("rst_mid_pre_valid", 64'(o_tx_valid), 64'd1);
    chk("rst_mid_pre_data", o_tx_data, exp_data(1, 54, 2));
    i_reset = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_mid_data", o_tx_data, 64'd0);
    chk("rst_mid_keep", 64'(o_tx_keep), 64'd0);
    chk("rst_mid_last", 64'(o_tx_last), 64'd0);
    chk("rst_mid_src", 64'(o_tx_src), 64'd0);
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    step();
    i_reset = 1'b0;
    count_valid(12, extra);
    chk("rst_mid_no_resume", 64'(extra), 64'd0);
    chk("rst_mid_idle_busy", 64'(o_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
